// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with one prefix level per stage and a global advance enable.
// Optional signed-overflow output is built only when KSA_PIPE_OVF_EN is defined.
module ksa_pipe_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  logic en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] p_bit;

  // Stage k holds the prefix result after k levels; stage 0 holds bitwise g/p.
  logic [LEVELS:0]              vld_q;
  logic [LEVELS:0][WIDTH-1:0]   g_q;
  logic [LEVELS:0][WIDTH-1:0]   g_d;
  logic [LEVELS-1:0][WIDTH-1:0] p_q;
  logic [LEVELS-1:0][WIDTH-1:0] p_d;
  logic [LEVELS:0][WIDTH-1:0]   pb_q;
  logic [LEVELS:0]              cin_q;

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign busy     = (|vld_q) | out_valid;

  // Operand conditioning: subtraction is A + ~B + 1.
  always_comb begin
    b_eff   = in_sub ? ~in_b : in_b;
    cin_eff = in_sub ? 1'b1 : in_cin;
    p_bit   = in_a ^ b_eff;
  end

  // Prefix network; carry-in is folded into bit 0's generate so G[i] is the carry out of bit i.
  always_comb begin
    int span;
    int j;
    g_d = '0;
    p_d = '0;
    g_d[0]    = in_a & b_eff;
    g_d[0][0] = (in_a[0] & b_eff[0]) | (p_bit[0] & cin_eff);
    p_d[0]    = p_bit;
    for (int k = 1; k <= int'(LEVELS); k++) begin
      span = 1 << (k - 1);
      for (int i = 0; i < int'(WIDTH); i++) begin
        j = (i >= span) ? (i - span) : i;
        if (i >= span) g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][j]);
        else           g_d[k][i] = g_q[k-1][i];
      end
    end
    for (int k = 1; k < int'(LEVELS); k++) begin
      span = 1 << (k - 1);
      for (int i = 0; i < int'(WIDTH); i++) begin
        j = (i >= span) ? (i - span) : i;
        if (i >= span) p_d[k][i] = p_q[k-1][i] & p_q[k-1][j];
        else           p_d[k][i] = p_q[k-1][i];
      end
    end
  end

  // Final sum from the fully resolved carries.
  always_comb begin
    carry  = {g_q[LEVELS], cin_q[LEVELS]};
    sum_d  = pb_q[LEVELS] ^ carry[WIDTH-1:0];
    cout_d = carry[WIDTH];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      vld_q     <= '0;
      g_q       <= '0;
      p_q       <= '0;
      pb_q      <= '0;
      cin_q     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else if (en) begin
      vld_q     <= {vld_q[LEVELS-1:0], in_valid};
      g_q       <= g_d;
      p_q       <= p_d;
      pb_q      <= {pb_q[LEVELS-1:0], p_bit};
      cin_q     <= {cin_q[LEVELS-1:0], cin_eff};
      out_valid <= vld_q[LEVELS];
      out_sum   <= sum_d;
      out_cout  <= cout_d;
    end
  end

`ifdef KSA_PIPE_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)  out_ovf <= 1'b0;
    else if (en)   out_ovf <= carry[WIDTH] ^ carry[WIDTH-1];
  end
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: doc/ksa_pipe_adder.md
KSA_PIPE_ADDER -- requirements
Module: ksa_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are powers of two from 4 to 64.
REQ-002 SHALL have derived localparam LEVELS = log2(WIDTH), the number of prefix levels.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand beat valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-007 SHALL have port in_a, input, WIDTH bits: operand A.
REQ-008 SHALL have port in_b, input, WIDTH bits: operand B.
REQ-009 SHALL have port in_cin, input, 1 bit: carry-in (add mode only).
REQ-010 SHALL have port in_sub, input, 1 bit: 1 selects A-B, 0 selects A+B+cin.
REQ-011 SHALL have port out_valid, output, 1 bit: result beat valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port out_sum, output, WIDTH bits: result.
REQ-014 SHALL have port out_cout, output, 1 bit: carry-out (inverted borrow in sub mode).
REQ-015 SHALL have port out_ovf, output, 1 bit: signed overflow (see Configuration).
REQ-016 SHALL have port busy, output, 1 bit: OR of all stage valid bits.

Function
REQ-017 SHALL form the adder as Kogge-Stone: bitwise g=a&b' and p=a^b'; LEVELS prefix levels with span 2^k at level k; sum = p ^ {carries, cin'}.
REQ-018 SHALL set b' = ~in_b and cin' = 1 when in_sub=1; otherwise b' = in_b and cin' = in_cin.
REQ-019 SHALL register the pipeline as follows: stage S0 captures b', cin' and bitwise g/p; stages S1..S_LEVELS each register one prefix level; the output stage registers sum, cout and ovf.
REQ-020 SHALL give a latency of LEVELS+1 edges: a beat accepted at edge N presents out_valid=1 after edge N+LEVELS+1 (5 for WIDTH=16).
REQ-021 SHALL accept a beat at an edge where in_valid & in_ready are both 1, and transfer a result at an edge where out_valid & out_ready are both 1.
REQ-022 SHALL use a global advance enable en = ~out_valid | out_ready, with in_ready = en; when en=0 every stage holds its contents, including its valid bit.
REQ-023 SHALL sustain throughput of one beat per cycle while out_ready=1.
REQ-024 SHALL carry bubbles through the pipeline; bubbles are not collapsed. A beat enters as a bubble when in_valid=0 and en=1.
REQ-025 SHALL hold out_sum, out_cout and out_ovf stable while out_valid=1 and out_ready=0.
REQ-026 SHALL preserve result order and SHALL never drop or duplicate a beat.
REQ-027 SHALL ignore in_a, in_b, in_cin and in_sub when in_valid=0 or in_ready=0.
REQ-028 SHALL compute cout as bit WIDTH of the full sum; for A-B, cout=1 when A>=B unsigned.

Reset
REQ-029 SHALL, while wb_rst_i=1, asynchronously clear all stage valid bits, out_valid, busy, out_sum, out_cout and out_ovf to 0.
REQ-030 SHALL discard any beat in flight when reset asserts mid-operation; no result for it SHALL emerge.
REQ-031 SHALL drive in_ready=1 during and after reset (follows from out_valid=0).
REQ-032 SHALL accept a beat at the first rising edge after wb_rst_i deasserts.

Configuration
REQ-033 SHALL use macro KSA_PIPE_OVF_EN to control signed overflow detection.
REQ-034 SHALL, when KSA_PIPE_OVF_EN is defined, set out_ovf = carry into MSB XOR carry out of MSB, registered and aligned with out_sum.
REQ-035 SHALL, when KSA_PIPE_OVF_EN is undefined, keep the out_ovf port, tie it to 0, and add no overflow logic.

Verification
REQ-036 SHALL check basic add latency: WIDTH=16, a=0xFFFF, b=0x0001, cin=0, sub=0 -> out_sum=0x0000, out_cout=1, out_valid exactly 5 edges after accept.
REQ-037 SHALL check subtract: a=0x0005, b=0x0007, sub=1 -> out_sum=0xFFFE, out_cout=0; a=0x0007, b=0x0005 -> 0x0002, cout=1.
REQ-038 SHALL check backpressure: 8 back-to-back beats with out_ready=0 from cycle 6 for 4 cycles -> in_ready=0 during the stall, outputs held, all 8 results in order, none lost.
REQ-039 SHALL check reset mid-flight: assert wb_rst_i 2 cycles after 3 accepts -> out_valid and busy go 0 immediately, and no stale result appears after release.
REQ-040 SHALL check overflow: a=0x7FFF, b=0x0001 -> out_sum=0x8000, out_ovf=1 with KSA_PIPE_OVF_EN and 0 without; a=0x8000, b=0x0001, sub=1 -> out_ovf=1 (macro on).
REQ-041 SHALL check WIDTH=32 and WIDTH=64: 10k random beats with random out_ready against a behavioural a±b model -> zero mismatches.
